// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM encoding,
// default bus widths and the port-select constants.
package memory_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/wait_counter.sv
// Saturating 3-bit counter of data grants that overtook a pending fetch.
module wait_counter #(
    parameter int MAX_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [2:0] count_o,
    output logic       sat_o
);

    assign sat_o = (count_o == 3'(MAX_COUNT));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_o <= 3'd0;
        end else if (clr) begin
            count_o <= 3'd0;
        end else if (inc && !sat_o) begin
            count_o <= count_o + 3'd1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory. Data wins,
// except that a fetch overtaken MAX_WAIT times in a row is forced through.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  If_Req_i,
    input  logic [ADDR_WIDTH-1:0] If_Addr_i,
    output logic                  If_Ack_o,
    output logic [DATA_WIDTH-1:0] If_Rdata_o,
    input  logic                  D_Req_i,
    input  logic                  D_We_i,
    input  logic [ADDR_WIDTH-1:0] D_Addr_i,
    input  logic [DATA_WIDTH-1:0] D_Wdata_i,
    output logic                  D_Ack_o,
    output logic [DATA_WIDTH-1:0] D_Rdata_o,
    output logic                  Mem_Req_o,
    output logic                  Mem_We_o,
    output logic [ADDR_WIDTH-1:0] Mem_Addr_o,
    output logic [DATA_WIDTH-1:0] Mem_Wdata_o,
    input  logic [DATA_WIDTH-1:0] Mem_Rdata_i,
    input  logic                  Mem_Ready_i,
    output logic                  Busy_o
);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  port_sel;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [2:0]            wait_cnt;
    logic                  wait_sat;
    logic                  grant_i;
    logic                  grant_d;

    wait_counter #(
        .MAX_COUNT (MAX_WAIT)
    ) u_wait_counter (
        .clk     (clk),
        .reset   (reset),
        .inc     (grant_d && If_Req_i),
        .clr     (grant_i),
        .count_o (wait_cnt),
        .sat_o   (wait_sat)
    );

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == ST_IDLE) begin
            if (D_Req_i && !(If_Req_i && wait_sat)) begin
                grant_d = 1'b1;
            end else if (If_Req_i) begin
                grant_i = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant_d) begin
                    state_next = ST_SERVE_D;
                end else if (grant_i) begin
                    state_next = ST_SERVE_I;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (Mem_Ready_i) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: reset clears every register, including the operand latches and
    // read-data holders, so nothing downstream ever sees X after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            port_sel   <= PORT_I;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            If_Rdata_o <= '0;
            D_Rdata_o  <= '0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                port_sel  <= PORT_D;
                lat_addr  <= D_Addr_i;
                lat_we    <= D_We_i;
                lat_wdata <= D_Wdata_i;
            end else if (grant_i) begin
                port_sel  <= PORT_I;
                lat_addr  <= If_Addr_i;
                lat_we    <= 1'b0;
                lat_wdata <= '0;
            end
            // Read data is only trusted while a SERVE state owns the memory.
            if (Mem_Ready_i && state == ST_SERVE_I) begin
                If_Rdata_o <= Mem_Rdata_i;
            end
            if (Mem_Ready_i && state == ST_SERVE_D && !lat_we) begin
                D_Rdata_o <= Mem_Rdata_i;
            end
        end
    end

    assign Mem_Req_o   = (state == ST_SERVE_I) || (state == ST_SERVE_D);
    assign Mem_We_o    = (state == ST_SERVE_D) && lat_we;
    assign Mem_Addr_o  = lat_addr;
    assign Mem_Wdata_o = lat_wdata;
    assign If_Ack_o    = (state == ST_DONE) && (port_sel == PORT_I);
    assign D_Ack_o     = (state == ST_DONE) && (port_sel == PORT_D);
    assign Busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a small memory model plus a
// scoreboard of expected acknowledges in service order.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 4;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          If_Req_i;
    logic [AW-1:0] If_Addr_i;
    logic          If_Ack_o;
    logic [DW-1:0] If_Rdata_o;
    logic          D_Req_i;
    logic          D_We_i;
    logic [AW-1:0] D_Addr_i;
    logic [DW-1:0] D_Wdata_i;
    logic          D_Ack_o;
    logic [DW-1:0] D_Rdata_o;
    logic          Mem_Req_o;
    logic          Mem_We_o;
    logic [AW-1:0] Mem_Addr_o;
    logic [DW-1:0] Mem_Wdata_o;
    logic [DW-1:0] Mem_Rdata_i;
    logic          Mem_Ready_i;
    logic          Busy_o;

    memory_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_WAIT   (MW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .If_Req_i    (If_Req_i),
        .If_Addr_i   (If_Addr_i),
        .If_Ack_o    (If_Ack_o),
        .If_Rdata_o  (If_Rdata_o),
        .D_Req_i     (D_Req_i),
        .D_We_i      (D_We_i),
        .D_Addr_i    (D_Addr_i),
        .D_Wdata_i   (D_Wdata_i),
        .D_Ack_o     (D_Ack_o),
        .D_Rdata_o   (D_Rdata_o),
        .Mem_Req_o   (Mem_Req_o),
        .Mem_We_o    (Mem_We_o),
        .Mem_Addr_o  (Mem_Addr_o),
        .Mem_Wdata_o (Mem_Wdata_o),
        .Mem_Rdata_i (Mem_Rdata_i),
        .Mem_Ready_i (Mem_Ready_i),
        .Busy_o      (Busy_o)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          mem_delay = 0;
    int          serve_cnt = 0;
    int          ack_count = 0;
    bit          if_ack_seen;
    bit          d_ack_seen;
    logic [31:0] exp_d_rdata;
    exp_t        sb[$];

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0000_0013;
        return a ^ 32'h5A5A_0000;
    endfunction

    // One clock: memory model response, then scoreboard check of any ack.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (Mem_Req_o === 1'b1) begin
            Mem_Ready_i = (serve_cnt >= mem_delay);
            Mem_Rdata_i = Mem_Ready_i ? mem_model(Mem_Addr_o) : JUNK;
            serve_cnt++;
        end else begin
            serve_cnt   = 0;
            Mem_Ready_i = 1'b1;
            Mem_Rdata_i = JUNK;
        end
        if_ack_seen = (If_Ack_o === 1'b1);
        d_ack_seen  = (D_Ack_o === 1'b1);
        if (if_ack_seen || d_ack_seen) begin
            ack_count++;
            checks++;
            if (if_ack_seen && d_ack_seen) begin
                errors++;
                $display("FAIL ack_onehot: If_Ack_o=1 D_Ack_o=1, required exactly one");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: If_Ack_o=%b D_Ack_o=%b, required no ack", If_Ack_o, D_Ack_o);
            end else begin
                e = sb.pop_front();
                if (D_Ack_o !== e.port) begin
                    errors++;
                    $display("FAIL ack_order: D_Ack_o=%b, required %b", D_Ack_o, e.port);
                end else if (e.port == PORT_D && D_Rdata_o !== e.rdata) begin
                    errors++;
                    $display("FAIL d_rdata: got %h, required %h", D_Rdata_o, e.rdata);
                end else if (e.port == PORT_I && If_Rdata_o !== e.rdata) begin
                    errors++;
                    $display("FAIL if_rdata: got %h, required %h", If_Rdata_o, e.rdata);
                end
            end
        end
    endtask

    task automatic wait_ack(input logic port, input int budget, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(port ? d_ack_seen : if_ack_seen) && n < budget);
        checks++;
        if (!(port ? d_ack_seen : if_ack_seen)) begin
            errors++;
            $display("FAIL %s_timeout: no ack after %0d cycles, required ack", name, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        If_Req_i = 1'b0; If_Addr_i = '0;
        D_Req_i = 1'b0; D_We_i = 1'b0; D_Addr_i = '0; D_Wdata_i = '0;
        Mem_Ready_i = 1'b1; Mem_Rdata_i = JUNK;
        exp_d_rdata = '0;
        repeat (3) tick();
        checks++;
        if ({If_Ack_o, D_Ack_o, Mem_Req_o, Mem_We_o, Busy_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ack/req/we/busy=%b, required 00000",
                     {If_Ack_o, D_Ack_o, Mem_Req_o, Mem_We_o, Busy_o});
        end
        checks++;
        if (If_Rdata_o !== '0 || D_Rdata_o !== '0) begin
            errors++;
            $display("FAIL reset_rdata: if=%h d=%h, required 0", If_Rdata_o, D_Rdata_o);
        end
        checks++;
        if (Mem_Addr_o !== '0 || Mem_Wdata_o !== '0) begin
            errors++;
            $display("FAIL reset_latch: addr=%h wdata=%h, required 0", Mem_Addr_o, Mem_Wdata_o);
        end
        checks++;
        if (dut.wait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_wait_cnt: got %0d, required 0", dut.wait_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch_alone();
        If_Req_i = 1'b1;
        If_Addr_i = 32'h0000_0040;
        sb.push_back('{PORT_I, 32'h0000_0013});
        tick();
        checks++;
        if (Mem_Req_o !== 1'b1 || Mem_We_o !== 1'b0 || Mem_Addr_o !== 32'h40 || Busy_o !== 1'b1) begin
            errors++;
            $display("FAIL fetch_serve: req=%b we=%b addr=%h busy=%b, required 1 0 00000040 1",
                     Mem_Req_o, Mem_We_o, Mem_Addr_o, Busy_o);
        end
        tick();
        checks++;
        if (If_Ack_o !== 1'b1 || D_Ack_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_latency: If_Ack_o=%b D_Ack_o=%b at cycle 2, required 1 0", If_Ack_o, D_Ack_o);
        end
        checks++;
        if (If_Rdata_o !== 32'h0000_0013) begin
            errors++;
            $display("FAIL fetch_rdata: got %h, required 00000013", If_Rdata_o);
        end
        If_Req_i = 1'b0;
        tick();
        checks++;
        if (Busy_o !== 1'b0 || If_Ack_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: busy=%b ack=%b at cycle 3, required 0 0", Busy_o, If_Ack_o);
        end
    endtask

    task automatic test_simultaneous();
        D_Req_i = 1'b1; D_We_i = 1'b0; D_Addr_i = 32'h0000_2000;
        exp_d_rdata = mem_model(32'h0000_2000);
        sb.push_back('{PORT_D, exp_d_rdata});
        wait_ack(PORT_D, 20, "load");
        D_Req_i = 1'b0;
        tick();

        sb.push_back('{PORT_D, exp_d_rdata});
        sb.push_back('{PORT_I, mem_model(32'h0000_0100)});
        If_Req_i = 1'b1; If_Addr_i = 32'h0000_0100;
        D_Req_i = 1'b1; D_We_i = 1'b1; D_Addr_i = 32'h1001_0000; D_Wdata_i = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (Mem_Req_o !== 1'b1 || Mem_We_o !== 1'b1 || Mem_Addr_o !== 32'h1001_0000 ||
            Mem_Wdata_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_first: req=%b we=%b addr=%h wdata=%h, required 1 1 10010000 deadbeef",
                     Mem_Req_o, Mem_We_o, Mem_Addr_o, Mem_Wdata_o);
        end
        wait_ack(PORT_D, 20, "store");
        D_Req_i = 1'b0; D_We_i = 1'b0;
        wait_ack(PORT_I, 20, "fetch_after_store");
        If_Req_i = 1'b0;
        tick();
        checks++;
        if (D_Rdata_o !== exp_d_rdata || Busy_o !== 1'b0) begin
            errors++;
            $display("FAIL store_keeps_rdata: d_rdata=%h busy=%b, required %h 0", D_Rdata_o, Busy_o, exp_d_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [5];
        int d_grants = 0;
        int k = 0;
        int n = 0;
        bit got_i = 1'b0;
        for (int i = 0; i < 5; i++) addrs[i] = 32'h0000_4000 + 32'(i * 16);
        for (int i = 0; i < 4; i++) sb.push_back('{PORT_D, mem_model(addrs[i])});
        sb.push_back('{PORT_I, mem_model(32'h0000_3000)});
        sb.push_back('{PORT_D, mem_model(addrs[4])});
        exp_d_rdata = mem_model(addrs[4]);
        If_Req_i = 1'b1; If_Addr_i = 32'h0000_3000;
        D_Req_i = 1'b1; D_We_i = 1'b0; D_Addr_i = addrs[0];
        while (k < 5 && n < 100) begin
            tick();
            n++;
            if (Mem_Req_o === 1'b1 && serve_cnt == 1) begin
                if (Mem_Addr_o === 32'h0000_3000) begin
                    got_i = 1'b1;
                    checks++;
                    if (d_grants != 4) begin
                        errors++;
                        $display("FAIL starve_grants: %0d data grants before fetch, required 4", d_grants);
                    end
                    checks++;
                    if (dut.wait_cnt !== 3'd0) begin
                        errors++;
                        $display("FAIL starve_clear: wait_cnt=%0d in SERVE_I, required 0", dut.wait_cnt);
                    end
                end else if (!got_i) begin
                    d_grants++;
                    if (d_grants == 4) begin
                        checks++;
                        if (dut.wait_cnt !== 3'd4) begin
                            errors++;
                            $display("FAIL starve_sat: wait_cnt=%0d after 4 grants, required 4", dut.wait_cnt);
                        end
                    end
                end
            end
            if (d_ack_seen) begin
                k++;
                if (k < 5) D_Addr_i = addrs[k];
                else D_Req_i = 1'b0;
            end
            if (if_ack_seen) If_Req_i = 1'b0;
        end
        checks++;
        if (k != 5 || !got_i) begin
            errors++;
            $display("FAIL starve_done: data acks=%0d fetch=%b, required 5 1", k, got_i);
        end
        If_Req_i = 1'b0; D_Req_i = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        mem_delay = 10;
        D_Req_i = 1'b1; D_We_i = 1'b0; D_Addr_i = 32'h0000_5000;
        exp_d_rdata = mem_model(32'h0000_5000);
        sb.push_back('{PORT_D, exp_d_rdata});
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (Mem_Req_o !== 1'b1 || Mem_Addr_o !== 32'h0000_5000 || D_Ack_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: req=%b addr=%h ack=%b, required 1 00005000 0",
                         i, Mem_Req_o, Mem_Addr_o, D_Ack_o);
            end
            D_Addr_i  = 32'h0000_6000 + 32'(i);
            If_Addr_i = 32'h0000_7000 + 32'(i);
            if (i < 9) tick();
        end
        wait_ack(PORT_D, 20, "stall");
        D_Req_i = 1'b0;
        mem_delay = 0;
        repeat (4) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stall_pending: %0d acks outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_abort();
        int acks_before;
        mem_delay = 3;
        D_Req_i = 1'b1; D_We_i = 1'b0; D_Addr_i = 32'h0000_7000;
        tick();
        checks++;
        if (Busy_o !== 1'b1 || Mem_Req_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: busy=%b req=%b, required 1 1", Busy_o, Mem_Req_o);
        end
        acks_before = ack_count;
        reset = 1'b1;
        Mem_Ready_i = 1'b1;
        Mem_Rdata_i = 32'h1234_5678;
        tick();
        checks++;
        if (Busy_o !== 1'b0 || Mem_Req_o !== 1'b0 || D_Ack_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b req=%b ack=%b, required 0 0 0", Busy_o, Mem_Req_o, D_Ack_o);
        end
        reset = 1'b0;
        D_Req_i = 1'b0;
        exp_d_rdata = '0;
        repeat (5) tick();
        checks++;
        if (ack_count != acks_before || Busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_ack: acks=%0d busy=%b, required %0d 0", ack_count, Busy_o, acks_before);
        end
        checks++;
        if (D_Rdata_o !== exp_d_rdata || If_Rdata_o !== '0) begin
            errors++;
            $display("FAIL abort_rdata: d=%h if=%h, required 0 0", D_Rdata_o, If_Rdata_o);
        end
        mem_delay = 0;
    endtask

    initial begin
        test_reset();
        test_fetch_alone();
        test_simultaneous();
        test_back_to_back();
        test_stall();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of all data buses.
REQ-002 Parameter: ADDR_WIDTH, default 32, width of all address buses.
REQ-003 Parameter: MAX_WAIT, default 4, range 1..7; number of consecutive data grants a pending fetch tolerates before it is forced.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- If_Req_i  in  1  fetch request.
- If_Addr_i  in  ADDR_WIDTH  fetch address.
- If_Ack_o  out  1  fetch complete, one-cycle pulse.
- If_Rdata_o  out  DATA_WIDTH  fetched instruction.
- D_Req_i  in  1  data request.
- D_We_i  in  1  1 = store, 0 = load.
- D_Addr_i  in  ADDR_WIDTH  data address.
- D_Wdata_i  in  DATA_WIDTH  store data.
- D_Ack_o  out  1  data complete, one-cycle pulse.
- D_Rdata_o  out  DATA_WIDTH  load data.
- Mem_Req_o  out  1  shared-memory request.
- Mem_We_o  out  1  shared-memory write enable.
- Mem_Addr_o  out  ADDR_WIDTH  shared-memory address.
- Mem_Wdata_o  out  DATA_WIDTH  shared-memory write data.
- Mem_Rdata_i  in  DATA_WIDTH  shared-memory read data.
- Mem_Ready_i  in  1  shared memory completes the current access this cycle.
- Busy_o  out  1  high in any state other than IDLE.

Function
REQ-006 The block SHALL implement the FSM states IDLE, SERVE_I, SERVE_D and DONE.
REQ-007 In IDLE with D_Req_i=1, the block SHALL go to SERVE_D, unless If_Req_i=1 and wait_cnt==MAX_WAIT, in which case it SHALL go to SERVE_I.
REQ-008 In IDLE with only If_Req_i=1, the block SHALL go to SERVE_I; with no request it SHALL stay in IDLE.
REQ-009 On the grant edge, the block SHALL latch the address, we and wdata of the granted port; Mem_*_o SHALL drive the latched values, not the live inputs.
REQ-010 In SERVE_I and SERVE_D, Mem_Req_o SHALL be 1, and Mem_We_o SHALL be 0 for fetch and the latched D_We_i for data; in all other states Mem_Req_o and Mem_We_o SHALL be 0.
REQ-011 In SERVE_x with Mem_Ready_i=1, the block SHALL go to DONE and capture Mem_Rdata_i into If_Rdata_o or, for data loads only, D_Rdata_o; otherwise it SHALL hold SERVE_x with no cycle limit.
REQ-012 In DONE, the block SHALL assert exactly one of If_Ack_o or D_Ack_o for one cycle, grant nothing, and then go to IDLE.
REQ-013 Minimum latency: request seen in IDLE at cycle 0, Mem_Req_o=1 at cycle 1, Mem_Ready_i=1 at cycle 1, Ack at cycle 2, next grant possible from IDLE at cycle 3.
REQ-014 Requesters SHALL hold Req and operands stable until Ack and deassert Req in the cycle after Ack; the arbiter does not check this.
REQ-015 wait_cnt (3 bits) SHALL increment, saturating at MAX_WAIT, on each SERVE_D grant while If_Req_i=1, and SHALL clear on each SERVE_I grant.
REQ-016 The block SHALL ignore Mem_Ready_i and Mem_Rdata_i outside SERVE_I and SERVE_D.
REQ-017 If_Rdata_o and D_Rdata_o SHALL hold their values until the next capture for that port; a store SHALL leave D_Rdata_o unchanged.

Reset
REQ-018 On reset, the block SHALL enter IDLE with wait_cnt=0, all *_Ack_o=0, Mem_Req_o=0, Mem_We_o=0, Busy_o=0, and all data, address and latch registers cleared to 0.
REQ-019 Reset during SERVE or DONE SHALL abort the transaction with no Ack; a Mem_Ready_i arriving after the abort SHALL be ignored.

Structure
REQ-020 The shared package SHALL hold the FSM state encoding (2 bits), the default DATA_WIDTH and ADDR_WIDTH, and the port-select constants PORT_I and PORT_D.
REQ-021 One sub-module SHALL exist: wait_counter (saturating counter with inc, clr and sat_o); everything else stays in memory_arbiter.

Verification
REQ-022 Fetch alone at 0x0000_0040, Mem_Ready_i high on the first SERVE cycle, Mem_Rdata_i=0x0000_0013 -> If_Ack_o pulses at cycle 2, If_Rdata_o=0x0000_0013, D_Ack_o stays 0.
REQ-023 Simultaneous fetch and store to 0x1001_0000 with data 0xDEAD_BEEF -> data served first with Mem_We_o=1 and Mem_Wdata_o=0xDEAD_BEEF; fetch acked afterwards; D_Rdata_o unchanged.
REQ-024 Fetch held high while data requests back-to-back, MAX_WAIT=4 -> exactly 4 data grants, then SERVE_I, then wait_cnt=0.
REQ-025 Mem_Ready_i withheld for 10 cycles -> Mem_Req_o and latched address stable for all 10 cycles, single Ack after ready.
REQ-026 Reset asserted in SERVE_D, with Mem_Ready_i=1 in the cycle after reset -> no Ack, Busy_o=0, Mem_Req_o=0 after reset.
